// File: rtl/stack_alu_driver_pkg.sv
// Shared opcode, error-code and FSM-state definitions for the stack ALU driver.
package stack_alu_driver_pkg;

   localparam logic [2:0] OpNop  = 3'b000;
   localparam logic [2:0] OpAdd  = 3'b100;
   localparam logic [2:0] OpMul  = 3'b101;
   localparam logic [2:0] OpPush = 3'b110;
   localparam logic [2:0] OpPop  = 3'b111;

   localparam logic [1:0] ErrOk    = 2'b00;
   localparam logic [1:0] ErrUnder = 2'b01;
   localparam logic [1:0] ErrFull  = 2'b10;
   localparam logic [1:0] ErrSp    = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StResp
   } state_e;

endpackage

// File: rtl/stack_alu_driver.sv
// Host-command front end for a stack ALU: range-checks each command against a shadow
// depth, issues legal ones for a single cycle and returns exactly one response per command.
module stack_alu_driver
   import stack_alu_driver_pkg::*;
#(
   parameter int unsigned N     = 16,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned SPW   = 5
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           cmd_valid,
   output logic           cmd_ready,
   input  logic [2:0]     cmd_op,
   input  logic [N-1:0]   cmd_data,
   output logic [2:0]     alu_opcode,
   output logic [N-1:0]   alu_data,
   input  logic [N-1:0]   alu_result,
   input  logic           alu_overflow,
   input  logic [SPW-1:0] alu_sp,
   output logic           rsp_valid,
   input  logic           rsp_ready,
   output logic [N-1:0]   rsp_data,
   output logic           rsp_overflow,
   output logic [1:0]     rsp_err
);

   localparam logic [SPW-1:0] DepthW = SPW'(DEPTH);

   state_e         state;
   logic [2:0]     op_q;
   logic [SPW-1:0] d_q;
   logic [SPW-1:0] d_upd;
   logic [1:0]     rej_err;

   // Legality of the presented command against the shadow depth.
   always_comb begin
      rej_err = ErrOk;
      unique case (cmd_op)
         OpPush:       if (d_q == DepthW)    rej_err = ErrFull;
         OpPop:        if (d_q == '0)        rej_err = ErrUnder;
         OpAdd, OpMul: if (d_q < SPW'(2))    rej_err = ErrUnder;
         default:                            rej_err = ErrUnder;
      endcase
   end

   assign d_upd = (op_q == OpPush) ? d_q + SPW'(1) : d_q - SPW'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= StIdle;
         op_q         <= OpNop;
         d_q          <= '0;
         cmd_ready    <= 1'b1;
         alu_opcode   <= OpNop;
         alu_data     <= '0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         rsp_overflow <= 1'b0;
         rsp_err      <= ErrOk;
      end else begin
         unique case (state)
            StIdle: begin
               if (cmd_valid) begin
                  op_q      <= cmd_op;
                  cmd_ready <= 1'b0;
                  if (rej_err == ErrOk) begin
                     state      <= StIssue;
                     alu_opcode <= cmd_op;
                     alu_data   <= cmd_data;
                  end else begin
                     state        <= StResp;
                     rsp_valid    <= 1'b1;
                     rsp_data     <= '0;
                     rsp_overflow <= 1'b0;
                     rsp_err      <= rej_err;
                  end
               end
            end
            StIssue: begin
               state      <= StWait;
               alu_opcode <= OpNop;
               alu_data   <= '0;
            end
            StWait: begin
               // ALU result is valid now; sp must agree with the post-update shadow depth.
               state        <= StResp;
               d_q          <= d_upd;
               rsp_valid    <= 1'b1;
               rsp_data     <= (op_q == OpPush) ? '0 : alu_result;
               rsp_overflow <= ((op_q == OpAdd) || (op_q == OpMul)) && alu_overflow;
               rsp_err      <= (alu_sp != d_upd) ? ErrSp : ErrOk;
            end
            StResp: begin
               if (rsp_ready) begin
                  state        <= StIdle;
                  cmd_ready    <= 1'b1;
                  rsp_valid    <= 1'b0;
                  rsp_data     <= '0;
                  rsp_overflow <= 1'b0;
                  rsp_err      <= ErrOk;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule
